// File: rtl/dcp_atmos_ctrl.sv
// rtl/dcp_atmos_ctrl.sv - per-frame atmospheric light estimator for dark-channel-prior dehazing
//
// Tracks the brightest dark-channel pixel of each frame and the RGB value of
// the source pixel behind it. At each frame boundary it checks the pixel count
// and publishes a temporally smoothed, clamped atmospheric light A.
//
// Ports:
//   pixelclk            pixel clock, the only clock
//   reset               synchronous active-high reset
//   i_vsync             frame sync level, rising edge = frame boundary
//   i_rgb               source pixel {R,G,B}, aligned with i_data_valid
//   i_data_valid        source pixel strobe (alignment reference only)
//   i_dark              dark-channel value, DARK_LAT cycles after its source pixel
//   i_dark_valid        dark-channel strobe
//   o_atmos_r/g/b       published A components
//   o_atmos_valid       set once the first good frame has been published
//   o_update            one-cycle pulse when new A takes effect
//   o_frame_err         one-cycle pulse when a finished frame has the wrong pixel count

module dcp_atmos_ctrl #(
    parameter int          DARK_LAT     = 2,
    parameter int          FRAME_PIXELS = 921600,
    parameter logic [7:0]  A_MIN        = 8'd100
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic        i_vsync,
    input  logic [23:0] i_rgb,
    input  logic        i_data_valid,
    input  logic [7:0]  i_dark,
    input  logic        i_dark_valid,
    output logic [7:0]  o_atmos_r,
    output logic [7:0]  o_atmos_g,
    output logic [7:0]  o_atmos_b,
    output logic        o_atmos_valid,
    output logic        o_update,
    output logic        o_frame_err
);

    localparam logic [21:0] L_FRAME_CNT = 22'(FRAME_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CHECK, S_UPDATE} state_t;

    state_t      r_state, w_next;
    logic        r_vsync;
    logic [23:0] r_rgb_dl [DARK_LAT];
    logic [21:0] r_cnt, r_snap_cnt;
    logic [7:0]  r_max_dark, r_snap_dark;
    logic [23:0] r_max_rgb, r_snap_rgb;
    logic        r_a_init;
    logic [7:0]  r_atmos_r, r_atmos_g, r_atmos_b;
    logic        r_update, r_frame_err;

    logic        w_boundary, w_clear, w_snap, w_upd, w_err;
    logic [23:0] w_rgb_d;
    logic [21:0] w_cnt_base;
    logic [7:0]  w_max_base;
    logic [23:0] w_rgb_base;
    logic        w_unused;

    // i_data_valid only documents the rgb/dark alignment
    assign w_unused   = i_data_valid;
    assign w_boundary = i_vsync & ~r_vsync;
    assign w_rgb_d    = r_rgb_dl[DARK_LAT-1];

    // On an accepted boundary the accumulators restart from zero, and a dark
    // pixel arriving in the same cycle is folded into the fresh frame.
    assign w_cnt_base = w_clear ? '0 : r_cnt;
    assign w_max_base = w_clear ? '0 : r_max_dark;
    assign w_rgb_base = w_clear ? '0 : r_max_rgb;

    // First good frame loads directly; later frames blend 3:1 old:new with
    // rounding. 3*255+255+2 = 1022 fits the 10-bit sum, so >>2 fits 8 bits.
    function automatic logic [7:0] f_blend(input logic [7:0] old_v,
                                           input logic [7:0] snap_v,
                                           input logic       init);
        logic [9:0] sum;
        logic [7:0] res;
        sum = {2'b00, old_v} + {1'b0, old_v, 1'b0} + {2'b00, snap_v} + 10'd2;
        res = init ? sum[9:2] : snap_v;
        return (res < A_MIN) ? A_MIN : res;
    endfunction

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_snap  = 1'b0;
        w_upd   = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_boundary) begin
                    w_clear = 1'b1;
                    w_next  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_boundary) begin
                    w_snap  = 1'b1;
                    w_clear = 1'b1;
                    w_next  = S_CHECK;
                end
            end
            // A and the pulses are registered on leaving CHECK so that they
            // are visible for exactly the cycle the FSM spends in UPDATE
            // (or the first ACCUM cycle after a rejected frame).
            S_CHECK: begin
                if (r_snap_cnt == L_FRAME_CNT) begin
                    w_upd  = 1'b1;
                    w_next = S_UPDATE;
                end else begin
                    w_err  = 1'b1;
                    w_next = S_ACCUM;
                end
            end
            S_UPDATE: w_next = S_ACCUM;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vsync     <= 1'b0;
            for (int i = 0; i < DARK_LAT; i++) r_rgb_dl[i] <= '0;
            r_cnt       <= '0;
            r_max_dark  <= '0;
            r_max_rgb   <= '0;
            r_snap_cnt  <= '0;
            r_snap_dark <= '0;
            r_snap_rgb  <= '0;
            r_a_init    <= 1'b0;
            r_atmos_r   <= 8'hFF;
            r_atmos_g   <= 8'hFF;
            r_atmos_b   <= 8'hFF;
            r_update    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_vsync     <= i_vsync;
            r_rgb_dl[0] <= i_rgb;
            for (int i = 1; i < DARK_LAT; i++) r_rgb_dl[i] <= r_rgb_dl[i-1];

            r_cnt      <= w_cnt_base;
            r_max_dark <= w_max_base;
            r_max_rgb  <= w_rgb_base;
            if (i_dark_valid) begin
                if (w_cnt_base != '1) r_cnt <= w_cnt_base + 22'd1;
                // strict compare: the first pixel reaching the max wins ties
                if (i_dark > w_max_base) begin
                    r_max_dark <= i_dark;
                    r_max_rgb  <= w_rgb_d;
                end
            end

            if (w_snap) begin
                r_snap_cnt  <= r_cnt;
                r_snap_dark <= r_max_dark;
                r_snap_rgb  <= r_max_rgb;
            end

            r_update    <= w_upd;
            r_frame_err <= w_err;
            if (w_upd) begin
                r_atmos_r <= f_blend(r_atmos_r, r_snap_rgb[23:16], r_a_init);
                r_atmos_g <= f_blend(r_atmos_g, r_snap_rgb[15:8],  r_a_init);
                r_atmos_b <= f_blend(r_atmos_b, r_snap_rgb[7:0],   r_a_init);
                r_a_init  <= 1'b1;
            end
        end
    end

    // the snapshot dark level is kept for observability of the chosen pixel
    logic [7:0] w_unused_dark;
    assign w_unused_dark = r_snap_dark;

    assign o_atmos_r     = r_atmos_r;
    assign o_atmos_g     = r_atmos_g;
    assign o_atmos_b     = r_atmos_b;
    assign o_atmos_valid = r_a_init;
    assign o_update      = r_update;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_dcp_atmos_ctrl.sv
// tb/tb_dcp_atmos_ctrl.sv - scoreboard bench for dcp_atmos_ctrl

module tb_dcp_atmos_ctrl;

    localparam int FP = 16;
    localparam int DL = 2;

    logic        pixelclk = 1'b0;
    logic        reset = 1'b1;
    logic        i_vsync = 1'b0;
    logic [23:0] i_rgb = '0;
    logic        i_data_valid = 1'b0;
    logic [7:0]  i_dark = '0;
    logic        i_dark_valid = 1'b0;
    logic [7:0]  o_atmos_r, o_atmos_g, o_atmos_b;
    logic        o_atmos_valid, o_update, o_frame_err;

    always #5 pixelclk = ~pixelclk;

    dcp_atmos_ctrl #(.DARK_LAT(DL), .FRAME_PIXELS(FP), .A_MIN(8'd100)) dut (
        .pixelclk     (pixelclk),
        .reset        (reset),
        .i_vsync      (i_vsync),
        .i_rgb        (i_rgb),
        .i_data_valid (i_data_valid),
        .i_dark       (i_dark),
        .i_dark_valid (i_dark_valid),
        .o_atmos_r    (o_atmos_r),
        .o_atmos_g    (o_atmos_g),
        .o_atmos_b    (o_atmos_b),
        .o_atmos_valid(o_atmos_valid),
        .o_update     (o_update),
        .o_frame_err  (o_frame_err)
    );

    typedef struct packed {
        logic        err;
        logic [23:0] a;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  f_dark [32];
    logic [23:0] f_rgb  [32];
    int          m_a [3];
    bit          m_init;

    function automatic int blend(int old_v, int snap_v, bit init);
        int v;
        v = init ? (3 * old_v + snap_v + 2) >> 2 : snap_v;
        if (v < 100) v = 100;
        return v;
    endfunction

    function automatic logic [23:0] model_a();
        return {m_a[0][7:0], m_a[1][7:0], m_a[2][7:0]};
    endfunction

    // outputs never pulse together, and A only moves while o_update is high
    logic [23:0] mon_prev;
    bit          mon_prev_ok = 0;
    always @(negedge pixelclk) begin
        if (!reset) begin
            n_tests++;
            if (o_update && o_frame_err) begin
                n_fail++;
                $display("FAIL pulse_overlap: update=%0b err=%0b required not both 1", o_update, o_frame_err);
            end
            if (mon_prev_ok) begin
                n_tests++;
                if ({o_atmos_r, o_atmos_g, o_atmos_b} !== mon_prev && !o_update) begin
                    n_fail++;
                    $display("FAIL a_stable: A=%06h changed from %06h without o_update",
                             {o_atmos_r, o_atmos_g, o_atmos_b}, mon_prev);
                end
            end
        end
        mon_prev    = {o_atmos_r, o_atmos_g, o_atmos_b};
        mon_prev_ok = !reset;
    end

    task automatic apply_reset();
        @(posedge pixelclk); #1;
        reset = 1'b1; i_vsync = 1'b0; i_data_valid = 1'b0; i_dark_valid = 1'b0;
        repeat (2) @(posedge pixelclk);
        #1 reset = 1'b0;
        m_init = 0;
        m_a    = '{255, 255, 255};
        sb.delete();
    endtask

    task automatic check_reset_outputs(string name);
        n_tests++;
        if ({o_atmos_r, o_atmos_g, o_atmos_b} !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL %s_a: got %06h required FFFFFF", name, {o_atmos_r, o_atmos_g, o_atmos_b});
        end
        n_tests++;
        if ({o_atmos_valid, o_update, o_frame_err} !== 3'b000) begin
            n_fail++; $display("FAIL %s_flags: got v/u/e=%03b required 000", name, {o_atmos_valid, o_update, o_frame_err});
        end
    endtask

    // boundary from IDLE: opens a frame, publishes nothing
    task automatic start_frame();
        @(posedge pixelclk); #1 i_vsync = 1'b1;
        @(posedge pixelclk); #1 i_vsync = 1'b0;
        repeat (2) begin
            @(posedge pixelclk); #1;
            n_tests++;
            if (o_update !== 1'b0 || o_frame_err !== 1'b0) begin
                n_fail++; $display("FAIL start_quiet: update=%0b err=%0b required 0/0", o_update, o_frame_err);
            end
        end
    endtask

    task automatic fill(int max_pos, logic [7:0] max_v, logic [23:0] max_rgb);
        for (int i = 0; i < 32; i++) begin
            f_dark[i] = 8'($urandom_range(0, int'(max_v) - 1));
            f_rgb[i]  = 24'($urandom);
        end
        f_dark[max_pos] = max_v;
        f_rgb[max_pos]  = max_rgb;
    endtask

    // drives n pixels with dark delayed DL cycles, then pushes the expectation
    task automatic run_frame(int n);
        int          md;
        logic [23:0] mr;
        for (int c = 0; c < n + DL; c++) begin
            @(posedge pixelclk); #1;
            i_data_valid = (c < n);
            i_rgb        = (c < n) ? f_rgb[c] : 24'h0;
            i_dark_valid = (c >= DL) && (c - DL < n);
            i_dark       = (c >= DL && c - DL < n) ? f_dark[c-DL] : 8'h0;
        end
        @(posedge pixelclk); #1;
        i_data_valid = 1'b0; i_dark_valid = 1'b0; i_rgb = '0; i_dark = '0;
        md = 0; mr = '0;
        for (int i = 0; i < n; i++) begin
            if (int'(f_dark[i]) > md) begin
                md = int'(f_dark[i]);
                mr = f_rgb[i];
            end
        end
        if (n == FP) begin
            for (int c = 0; c < 3; c++) m_a[c] = blend(m_a[c], int'(mr[23-8*c -: 8]), m_init);
            m_init = 1;
            sb.push_back('{err: 1'b0, a: model_a()});
        end else begin
            sb.push_back('{err: 1'b1, a: model_a()});
        end
    endtask

    // boundary at cycle T; result must appear during T+2 and last one cycle
    task automatic end_frame(string name);
        exp_t e;
        @(posedge pixelclk); #1 i_vsync = 1'b1;
        @(posedge pixelclk); #1 i_vsync = 1'b0;
        n_tests++;
        if (o_update !== 1'b0 || o_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL %s_early: update=%0b err=%0b at T+1 required 0/0", name, o_update, o_frame_err);
        end
        @(posedge pixelclk); #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_sb: scoreboard empty required one entry", name);
        end else begin
            e = sb.pop_front();
            n_tests++;
            if ({o_update, o_frame_err} !== (e.err ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL %s_pulse: update/err=%0b%0b required %0b%0b",
                                   name, o_update, o_frame_err, !e.err, e.err);
            end
            n_tests++;
            if ({o_atmos_r, o_atmos_g, o_atmos_b} !== e.a) begin
                n_fail++; $display("FAIL %s_a: got %06h required %06h", name, {o_atmos_r, o_atmos_g, o_atmos_b}, e.a);
            end
            n_tests++;
            if (o_atmos_valid !== m_init) begin
                n_fail++; $display("FAIL %s_valid: got %0b required %0b", name, o_atmos_valid, m_init);
            end
        end
        @(posedge pixelclk); #1;
        n_tests++;
        if (o_update !== 1'b0 || o_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL %s_width: update=%0b err=%0b at T+3 required 0/0", name, o_update, o_frame_err);
        end
    endtask

    task automatic check_a(string name, logic [23:0] want);
        n_tests++;
        if ({o_atmos_r, o_atmos_g, o_atmos_b} !== want) begin
            n_fail++; $display("FAIL %s: got %06h required %06h", name, {o_atmos_r, o_atmos_g, o_atmos_b}, want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_first_frame();
        start_frame();
        fill(5, 8'd200, 24'hF0E0D0);
        run_frame(FP);
        end_frame("first");
        check_a("first_lit", 24'hF0E0D0);
    endtask

    task automatic test_iir();
        fill(7, 8'd220, 24'h808080);
        run_frame(FP);
        end_frame("iir");
        check_a("iir_lit", 24'hD4C8BC);
    endtask

    task automatic test_bad_count();
        fill(4, 8'd250, 24'h112233);
        run_frame(FP - 1);
        end_frame("bad");
        check_a("bad_hold", 24'hD4C8BC);
    endtask

    task automatic test_tie();
        fill(3, 8'd150, 24'hC8C8C8);
        f_dark[9] = 8'd150;
        f_rgb[9]  = 24'h101010;
        run_frame(FP);
        end_frame("tie");
        check_a("tie_lit", 24'hD1C8BF);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            fill(int'($urandom_range(0, FP - 1)), 8'($urandom_range(60, 255)), 24'($urandom));
            run_frame(FP);
            end_frame("b2b");
        end
    endtask

    task automatic test_dim();
        apply_reset();
        start_frame();
        fill(2, 8'd50, 24'h403020);
        run_frame(FP);
        end_frame("dim");
        check_a("dim_lit", 24'h646464);
    endtask

    task automatic test_mid_reset();
        fill(1, 8'd90, 24'h777777);
        run_frame(8);
        apply_reset();
        check_reset_outputs("midrst");
        start_frame();
        fill(5, 8'd200, 24'hF0E0D0);
        run_frame(FP);
        end_frame("midrst_first");
        check_a("midrst_lit", 24'hF0E0D0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_iir();
        test_bad_count();
        test_tie();
        test_back_to_back();
        test_dim();
        test_mid_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcp_atmos_ctrl.md
# dcp_atmos_ctrl

Per-frame controller for the dark-channel prior dehazing chain. It watches the dark-channel stream produced by the RGB-minimum stage and tracks, per frame, the brightest dark-channel pixel and that pixel's original RGB value. It checks the frame's pixel count and, at each frame boundary, publishes a temporally smoothed atmospheric light estimate A (R/G/B) to the downstream transmission/recovery stages. Bad frames are flagged and never alter A.

## Interface
- DARK_LAT, 2: latency in cycles from `i_rgb`/`i_data_valid` to the matching `i_dark`/`i_dark_valid`.
- FRAME_PIXELS, 921600: expected number of valid dark pixels per frame (1280x720).
- A_MIN, 8'd100: lower clamp applied to each published A component.

- pixelclk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- i_vsync  in  1  frame sync level; a rising edge marks a frame boundary.
- i_rgb  in  24  source pixel {R[23:16], G[15:8], B[7:0]}, aligned with `i_data_valid`.
- i_data_valid  in  1  source pixel strobe.
- i_dark  in  8  dark-channel value, DARK_LAT cycles after its source pixel.
- i_dark_valid  in  1  dark-channel strobe.
- o_atmos_r / o_atmos_g / o_atmos_b  out  8 each  published A components.
- o_atmos_valid  out  1  high once the first good frame has been published; held until reset.
- o_update  out  1  one-cycle pulse when new A values take effect.
- o_frame_err  out  1  one-cycle pulse when a completed frame fails the count check.

## Operation
- **RGB delay line.** `i_rgb` passes through a DARK_LAT-stage delay line so that `rgb_d` is aligned with `i_dark`. `i_data_valid` is not used beyond documenting the alignment.
- **Accumulator.** Updated on each `i_dark_valid`:
  - `cnt` increments, 22 bits, saturating at all-ones.
  - If `i_dark > max_dark` (strictly greater), load `max_dark <= i_dark` and `max_rgb <= rgb_d`. On ties, the first occurrence wins.
- **Frame boundary.** Boundary = `i_vsync` high while its registered copy is low. On a boundary accepted in ACCUM, in the same cycle:
  - snapshot `cnt`, `max_dark` and `max_rgb` into hold registers;
  - clear the accumulators to 0;
  - a pixel valid in that same cycle is counted in the new frame.
- **State machine:**
  - IDLE: wait for a boundary, then clear the accumulators and go to ACCUM. No snapshot is taken.
  - ACCUM: accumulate. On a boundary, snapshot and go to CHECK.
  - CHECK (1 cycle): if `snap_cnt == FRAME_PIXELS`, go to UPDATE. Otherwise pulse `o_frame_err` and return to ACCUM.
  - UPDATE (1 cycle): compute and register A, pulse `o_update`, return to ACCUM.
  - Boundaries arriving in CHECK or UPDATE are ignored: no snapshot, no clear, and accumulation continues.
- **A computation (per component c):**
  - First good frame (`a_init == 0`): `A_c = snap_c`. Set `a_init` and `o_atmos_valid`.
  - Later frames: `A_c = (3*A_c_old + snap_c + 2) >> 2`, using a 10-bit intermediate. The result never overflows 8 bits.
  - Then clamp: `A_c = max(A_c, A_MIN)`.
- **Reset values** (reset has priority over everything, including mid-frame):
  - `o_atmos_r/g/b = 8'hFF`; `o_atmos_valid`, `o_update`, `o_frame_err` = 0.
  - state = IDLE; `a_init` = 0; accumulators, snapshots and the delay line = 0.

## Timing
- Boundary at cycle T (`i_vsync` rising seen at T, registered edge detect):
  - snapshot at the T+1 clock edge, state = CHECK;
  - good frame: `o_update` high during T+2, new `o_atmos_*` valid from T+2 onward;
  - bad frame: `o_frame_err` high during T+2 and `o_atmos_*` unchanged.
- `o_atmos_*` change only in the cycle `o_update` is asserted and are stable between updates.
- `o_update` and `o_frame_err` are never high together and are never high for more than one consecutive cycle.
- `i_dark_valid` may stay high on every cycle; there is no backpressure.

## Test plan
- Reset, then FRAME_PIXELS=16. Send a boundary, 16 pixels with max dark 200 at pixel 5 (rgb 0xF0E0D0), then a boundary -> `o_update` two cycles after the edge; A = F0/E0/D0; `o_atmos_valid` = 1.
- Second frame with max rgb 0x808080 -> A_r = (3*240+128+2)>>2 = 212, A_g = 200, A_b = 188.
- Frame with only 15 valid pixels -> `o_frame_err` pulses; A holds 212/200/188; `o_update` stays 0.
- Tie: dark 150 at pixels 3 and 9 with different RGB -> A taken from pixel 3.
- Dim frame as the first good frame, rgb 0x403020 -> all components clamp to 100 (0x64).
- Assert reset mid-frame, then run a good frame -> outputs return to FF/0; the first good frame loads A directly with no IIR blending.
